ssb_arbiter: RTL and testbench
==============================

# ssb_arbiter

Shared-system-bus arbiter for `ibex_super_system`. It shares one request/grant/rvalid device port (SRAM, debug memory, peripherals) between `NrHosts` bus hosts: host 0 is the debug module SBA, host 1 is Ibex instruction fetch and host 2 is Ibex data. It tracks outstanding transactions in an in-order ID FIFO, routes each response back to the host that issued it, and holds a stalled selection stable until the device grants it.

## Interface
- `NrHosts`, 3: number of hosts; 2..8.
- `AddrWidth`, 32: address width.
- `DataWidth`, 32: data width; byte enables are `DataWidth/8`.
- `MaxOutstanding`, 2: ID FIFO depth, i.e. the maximum number of granted transactions still awaiting `dev_rvalid_i`; 1..4.
- `clk_sys_i`  in  1  system clock.
- `rst_sys_i`  in  1  synchronous, active-high reset.
- `host_req_i`  in  NrHosts  per-host request.
- `host_addr_i`  in  NrHosts*AddrWidth  per-host address; host i occupies slice `[i*AddrWidth +: AddrWidth]`.
- `host_we_i`  in  NrHosts  per-host write enable.
- `host_be_i`  in  NrHosts*DataWidth/8  per-host byte enables.
- `host_wdata_i`  in  NrHosts*DataWidth  per-host write data.
- `host_gnt_o`  out  NrHosts  one-hot grant.
- `host_rvalid_o`  out  NrHosts  one-hot response valid.
- `host_rdata_o`  out  DataWidth  response data, broadcast to all hosts.
- `host_err_o`  out  NrHosts  response error, qualified by `host_rvalid_o`.
- `dev_req_o`, `dev_addr_o`, `dev_we_o`, `dev_be_o`, `dev_wdata_o`  out  device request channel.
- `dev_gnt_i`  in  1  device grant.
- `dev_rvalid_i`, `dev_rdata_i`, `dev_err_i`  in  device response channel; responses return in order.
- `protocol_err_o`  out  1  sticky flag: `dev_rvalid_i` arrived while the FIFO was empty.

## Operation
- **Selection.**
  - When unlocked, `sel` is computed combinationally from `host_req_i` by the arbitration policy (see Configuration).
  - `dev_*` outputs carry `sel`'s fields. They are 0 when no request is present.
- **Lock.**
  - If `dev_req_o=1` and `dev_gnt_i=0`, the register `lock_q` is set and `sel` is stored in `lock_id_q`.
  - While locked, `sel=lock_id_q` regardless of other requests.
  - The lock clears on the handshake.
  - Hosts must hold their request stable until granted (OBI rule).
- **Request gating.** `dev_req_o = |host_req_i & (count < MaxOutstanding | dev_rvalid_i)`. A same-cycle pop frees a slot.
- **Handshake.**
  - A handshake is `dev_req_o & dev_gnt_i`.
  - It drives `host_gnt_o[sel]=1`, pushes `sel` into the ID FIFO, and updates the round-robin pointer when round-robin is compiled in.
- **Response.**
  - `dev_rvalid_i` with a non-empty FIFO pops the head `h` and drives `host_rvalid_o[h]=1`.
  - `host_err_o[h]` is driven from `dev_err_i`.
  - `host_rdata_o` always equals `dev_rdata_i`.
- **Empty-FIFO response.** `dev_rvalid_i` with an empty FIFO is dropped, no `host_rvalid_o` is raised, and `protocol_err_o` is set. `protocol_err_o` clears only on reset.
- **Simultaneous push and pop.** The count is unchanged and the head/tail pointers both advance modulo `MaxOutstanding`.
- **Reset.**
  - `rst_sys_i=1` clears the FIFO, count, lock, RR pointer and `protocol_err_o`.
  - `dev_req_o`, `host_gnt_o` and `host_rvalid_o` are forced to 0 during reset.
  - In-flight responses are discarded. The device is reset by the same signal.

## Timing
- Arbitration and the request path are combinational: request to `dev_req_o` takes 0 cycles, and `dev_gnt_i` to `host_gnt_o` takes 0 cycles.
- The response path is combinational: `dev_rvalid_i` to `host_rvalid_o` takes 0 cycles.
- Registered state: the ID FIFO, count, `lock_q`, `lock_id_q`, the RR pointer and `protocol_err_o`.
- Throughput is one grant per cycle while the device grants every cycle and responds one cycle later with `MaxOutstanding>=1`.
- Reset values:
  - all registers 0;
  - `host_gnt_o`, `host_rvalid_o`, `host_err_o`, `dev_req_o` and `protocol_err_o` are 0;
  - `dev_*` data fields are 0.

## Configuration
- Macro: `SSB_ARB_RR_EN`.
- **Defined:**
  - Host 0 (debug) keeps absolute priority.
  - Hosts 1..NrHosts-1 are served round-robin. The search starts at the pointer and the pointer becomes "granted index + 1" (wrapping to 1) on each handshake to hosts ≥1.
- **Undefined:**
  - Fixed priority: the lowest requesting index wins.
  - No pointer register exists.

## Test plan
- **Fixed-priority order.** Macro undefined; hosts 1 and 2 request continuously; device grants every cycle and responds 1 cycle later. Required: host 1 gets every grant and host 2 starves.
- **Round-robin order.** Macro defined; hosts 1 and 2 request continuously. Required: grants alternate 1, 2, 1, 2. Then host 0 requests in cycle 5, and host 0 must be granted in cycle 5.
- **Lock.** Host 2 requests and `dev_gnt_i` is held at 0 for 3 cycles; host 1 requests in cycle 1. Required: `dev_addr_o` stays equal to host 2's address until its grant in cycle 3, and host 1 is granted in cycle 4.
- **FIFO full.** `MaxOutstanding=2`; device grants every cycle and responds 4 cycles late. Required: two grants, then `dev_req_o=0` until the first `dev_rvalid_i`. In the `dev_rvalid_i` cycle, `dev_req_o=1` and a grant is allowed.
- **Response routing.** Grants go to hosts 2, 1, 2 in sequence, with responses of `rdata` 0xA, 0xB, 0xC and `dev_err_i` on the second. Required: `host_rvalid_o` sequence 100b, 010b, 100b; `host_err_o[1]=1` only with 0xB.
- **Protocol error and reset.** Drive `dev_rvalid_i` with an empty FIFO. Required: `protocol_err_o=1` and no `host_rvalid_o`. Assert `rst_sys_i` with 2 transactions outstanding. Required: count 0 and a later `dev_rvalid_i` sets `protocol_err_o` again.

Source files
------------

// File: rtl/ssb_arbiter.sv
// ============================================================================
//  Module   : ssb_arbiter
//  Purpose  : Shared-system-bus arbiter with an in-order response ID FIFO.
//             Round-robin among hosts 1..NrHosts-1 when SSB_ARB_RR_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssb_arbiter #(
    parameter int NrHosts        = 3,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                           clk_sys_i,
    input  logic                           rst_sys_i,
    input  logic [NrHosts-1:0]             host_req_i,
    input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]             host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0] host_be_i,
    input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]             host_gnt_o,
    output logic [NrHosts-1:0]             host_rvalid_o,
    output logic [DataWidth-1:0]           host_rdata_o,
    output logic [NrHosts-1:0]             host_err_o,
    output logic                           dev_req_o,
    output logic [AddrWidth-1:0]           dev_addr_o,
    output logic                           dev_we_o,
    output logic [DataWidth/8-1:0]         dev_be_o,
    output logic [DataWidth-1:0]           dev_wdata_o,
    input  logic                           dev_gnt_i,
    input  logic                           dev_rvalid_i,
    input  logic [DataWidth-1:0]           dev_rdata_i,
    input  logic                           dev_err_i,
    output logic                           protocol_err_o
);

    localparam int c_ID_W  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int c_PTR_W = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int c_CNT_W = $clog2(MaxOutstanding + 1);
    localparam int c_BE_W  = DataWidth / 8;
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MaxOutstanding);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MaxOutstanding - 1);

    logic [c_ID_W-1:0]  r_fifo [MaxOutstanding];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_lock;
    logic [c_ID_W-1:0]  r_lock_id;
    logic               r_protocol_err;

    logic [c_ID_W-1:0]  w_pick;
    logic [c_ID_W-1:0]  w_sel;
    logic [c_ID_W-1:0]  w_head;
    logic               w_any_req;
    logic               w_fields_en;
    logic               w_hs;
    logic               w_pop;
    logic               w_drop;

`ifdef SSB_ARB_RR_EN
    logic [c_ID_W-1:0]  r_rr_ptr;

    // Host 0 always wins; the rest are searched cyclically from the pointer.
    always_comb begin : p_pick
        int   v_start;
        int   v_idx;
        logic v_found;
        w_pick  = '0;
        v_found = host_req_i[0];
        v_start = (r_rr_ptr == '0) ? 1 : int'(r_rr_ptr);
        for (int k = 0; k < NrHosts - 1; k++) begin
            v_idx = v_start + k;
            if (v_idx >= NrHosts) begin
                v_idx = v_idx - (NrHosts - 1);
            end
            if (!v_found && host_req_i[v_idx]) begin
                w_pick  = c_ID_W'(v_idx);
                v_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_rr_ptr <= '0;
        end else if (w_hs && (w_sel != '0)) begin
            r_rr_ptr <= (w_sel == c_ID_W'(NrHosts - 1)) ? c_ID_W'(1) : w_sel + c_ID_W'(1);
        end
    end
`else
    always_comb begin
        w_pick = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (host_req_i[i]) begin
                w_pick = c_ID_W'(i);
            end
        end
    end
`endif

    assign w_sel       = r_lock ? r_lock_id : w_pick;
    assign w_head      = r_fifo[r_rptr];
    assign w_any_req   = |host_req_i;
    assign w_fields_en = w_any_req & ~rst_sys_i;

    // A response in the same cycle frees the slot the new grant would use.
    assign dev_req_o = w_fields_en & ((r_count < c_MAX_CNT) | dev_rvalid_i);
    assign w_hs      = dev_req_o & dev_gnt_i;
    assign w_pop     = ~rst_sys_i & dev_rvalid_i & (r_count != '0);
    assign w_drop    = ~rst_sys_i & dev_rvalid_i & (r_count == '0);

    assign dev_addr_o  = w_fields_en ? host_addr_i[w_sel*AddrWidth +: AddrWidth] : '0;
    assign dev_we_o    = w_fields_en ? host_we_i[w_sel] : 1'b0;
    assign dev_be_o    = w_fields_en ? host_be_i[w_sel*c_BE_W +: c_BE_W] : '0;
    assign dev_wdata_o = w_fields_en ? host_wdata_i[w_sel*DataWidth +: DataWidth] : '0;

    assign host_gnt_o     = w_hs  ? (NrHosts'(1) << w_sel)  : '0;
    assign host_rvalid_o  = w_pop ? (NrHosts'(1) << w_head) : '0;
    assign host_err_o     = (w_pop & dev_err_i) ? (NrHosts'(1) << w_head) : '0;
    assign host_rdata_o   = dev_rdata_i;
    assign protocol_err_o = r_protocol_err;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_lock         <= 1'b0;
            r_lock_id      <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + c_PTR_W'(1);
            end
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A stalled request keeps its selection until the device takes it.
            if (w_hs) begin
                r_lock <= 1'b0;
            end else if (dev_req_o) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end
            if (w_drop) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ssb_arbiter.sv
// ============================================================================
//  Module   : tb_ssb_arbiter
//  Purpose  : Directed self-checking bench for ssb_arbiter (3 hosts, depth 2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssb_arbiter;

    logic        clk_sys_i = 1'b0;
    logic        rst_sys_i;
    logic [2:0]  host_req_i;
    logic [95:0] host_addr_i;
    logic [2:0]  host_we_i;
    logic [11:0] host_be_i;
    logic [95:0] host_wdata_i;
    logic [2:0]  host_gnt_o;
    logic [2:0]  host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic [2:0]  host_err_o;
    logic        dev_req_o;
    logic [31:0] dev_addr_o;
    logic        dev_we_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_wdata_o;
    logic        dev_gnt_i;
    logic        dev_rvalid_i;
    logic [31:0] dev_rdata_i;
    logic        dev_err_i;
    logic        protocol_err_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] exp_g [0:5];

    ssb_arbiter #(
        .NrHosts(3), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)
    ) dut (
        .clk_sys_i     (clk_sys_i),
        .rst_sys_i     (rst_sys_i),
        .host_req_i    (host_req_i),
        .host_addr_i   (host_addr_i),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_wdata_i  (host_wdata_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_addr_o    (dev_addr_o),
        .dev_we_o      (dev_we_o),
        .dev_be_o      (dev_be_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_gnt_i     (dev_gnt_i),
        .dev_rvalid_i  (dev_rvalid_i),
        .dev_rdata_i   (dev_rdata_i),
        .dev_err_i     (dev_err_i),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_sys_i    = 1'b1;
        host_req_i   = 3'b000;
        host_addr_i  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        host_we_i    = 3'b101;
        host_be_i    = {4'hC, 4'h3, 4'hF};
        host_wdata_i = {32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = '0;
        dev_err_i    = 1'b0;
`ifdef SSB_ARB_RR_EN
        exp_g = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b001};
`else
        exp_g = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
`endif
        cyc();

        // Reset forces request, grant and response outputs low.
        host_req_i = 3'b111; dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1;
        #2;
        chk("rst_dev_req", dev_req_o, 0);
        chk("rst_gnt", host_gnt_o, 0);
        chk("rst_rvalid", host_rvalid_o, 0);
        chk("rst_addr", dev_addr_o, 0);
        cyc();
        chk("rst_perr", protocol_err_o, 0);
        rst_sys_i = 1'b0; host_req_i = 3'b000; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0;
        #2;
        chk("idle_dev_req", dev_req_o, 0);
        chk("idle_addr", dev_addr_o, 0);
        cyc();

        // Arbitration order with hosts 1 and 2 requesting, host 0 joins in cycle 5.
        for (int k = 0; k < 6; k++) begin
            host_req_i   = (k == 5) ? 3'b111 : 3'b110;
            dev_gnt_i    = 1'b1;
            dev_rvalid_i = (k > 0);
            dev_rdata_i  = 32'(k);
            #2;
            chk("arb_gnt", host_gnt_o, exp_g[k]);
            chk("arb_rdata", host_rdata_o, 32'(k));
            if (k > 0) chk("arb_rvalid", host_rvalid_o, exp_g[k-1]);
            if (k == 0) chk("arb_addr_h1", dev_addr_o, 32'h0000_2000);
            if (k == 5) begin
                chk("arb_addr_h0", dev_addr_o, 32'h0000_1000);
                chk("arb_we_h0", dev_we_o, 1);
                chk("arb_be_h0", dev_be_o, 4'hF);
                chk("arb_wdata_h0", dev_wdata_o, 32'hA0A0_A0A0);
            end
            cyc();
        end
        host_req_i = 3'b000; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        #2;
        chk("arb_drain", host_rvalid_o, 3'b001);
        cyc();
        dev_rvalid_i = 1'b0;

        // Lock: host 2 stalls for three cycles while host 1 begins requesting.
        host_req_i = 3'b100;
        #2;
        chk("lock_addr0", dev_addr_o, 32'h0000_3000);
        chk("lock_req0", dev_req_o, 1);
        chk("lock_gnt0", host_gnt_o, 0);
        cyc();
        host_req_i = 3'b110;
        #2;
        chk("lock_addr1", dev_addr_o, 32'h0000_3000);
        chk("lock_wdata1", dev_wdata_o, 32'hC2C2_C2C2);
        cyc();
        #2;
        chk("lock_addr2", dev_addr_o, 32'h0000_3000);
        chk("lock_gnt2", host_gnt_o, 0);
        cyc();
        dev_gnt_i = 1'b1;
        #2;
        chk("lock_gnt3", host_gnt_o, 3'b100);
        chk("lock_addr3", dev_addr_o, 32'h0000_3000);
        cyc();
        host_req_i = 3'b010;
        #2;
        chk("lock_gnt4", host_gnt_o, 3'b010);
        chk("lock_addr4", dev_addr_o, 32'h0000_2000);
        cyc();
        host_req_i = 3'b000; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        #2;
        chk("lock_rsp_h2", host_rvalid_o, 3'b100);
        cyc();
        #2;
        chk("lock_rsp_h1", host_rvalid_o, 3'b010);
        cyc();
        dev_rvalid_i = 1'b0;

        // FIFO full: responses arrive four cycles after each grant.
        host_req_i = 3'b010; dev_gnt_i = 1'b1;
        #2;
        chk("full_gnt0", host_gnt_o, 3'b010);
        cyc();
        #2;
        chk("full_gnt1", host_gnt_o, 3'b010);
        cyc();
        #2;
        chk("full_req2", dev_req_o, 0);
        chk("full_gnt2", host_gnt_o, 0);
        cyc();
        #2;
        chk("full_req3", dev_req_o, 0);
        cyc();
        dev_rvalid_i = 1'b1;
        #2;
        chk("full_req4", dev_req_o, 1);
        chk("full_gnt4", host_gnt_o, 3'b010);
        chk("full_rsp4", host_rvalid_o, 3'b010);
        cyc();
        #2;
        chk("full_gnt5", host_gnt_o, 3'b010);
        cyc();
        host_req_i = 3'b000; dev_gnt_i = 1'b0;
        #2;
        chk("full_drain6", host_rvalid_o, 3'b010);
        cyc();
        #2;
        chk("full_drain7", host_rvalid_o, 3'b010);
        cyc();
        dev_rvalid_i = 1'b0;

        // Response routing: grants to 2, 1, 2; error flagged on the middle response.
        host_req_i = 3'b100; dev_gnt_i = 1'b1;
        #2;
        chk("route_gnt0", host_gnt_o, 3'b100);
        cyc();
        host_req_i = 3'b010; dev_rvalid_i = 1'b1; dev_rdata_i = 32'hA; dev_err_i = 1'b0;
        #2;
        chk("route_gnt1", host_gnt_o, 3'b010);
        chk("route_rv_a", host_rvalid_o, 3'b100);
        chk("route_err_a", host_err_o, 3'b000);
        chk("route_data_a", host_rdata_o, 32'hA);
        cyc();
        host_req_i = 3'b100; dev_rdata_i = 32'hB; dev_err_i = 1'b1;
        #2;
        chk("route_gnt2", host_gnt_o, 3'b100);
        chk("route_rv_b", host_rvalid_o, 3'b010);
        chk("route_err_b", host_err_o, 3'b010);
        chk("route_data_b", host_rdata_o, 32'hB);
        cyc();
        host_req_i = 3'b000; dev_gnt_i = 1'b0; dev_rdata_i = 32'hC; dev_err_i = 1'b0;
        #2;
        chk("route_rv_c", host_rvalid_o, 3'b100);
        chk("route_err_c", host_err_o, 3'b000);
        cyc();
        dev_rvalid_i = 1'b0;
        #2;
        chk("route_perr_clear", protocol_err_o, 0);

        // Empty-FIFO response is dropped and flagged.
        dev_rvalid_i = 1'b1;
        #2;
        chk("perr_no_rvalid", host_rvalid_o, 0);
        cyc();
        dev_rvalid_i = 1'b0;
        #2;
        chk("perr_set", protocol_err_o, 1);
        cyc();

        // Reset with two transactions outstanding empties the FIFO.
        host_req_i = 3'b010; dev_gnt_i = 1'b1;
        cyc();
        cyc();
        host_req_i = 3'b000; dev_gnt_i = 1'b0; rst_sys_i = 1'b1; dev_rvalid_i = 1'b1;
        #2;
        chk("rst2_rvalid", host_rvalid_o, 0);
        cyc();
        rst_sys_i = 1'b0; dev_rvalid_i = 1'b0;
        #2;
        chk("rst2_perr_clr", protocol_err_o, 0);
        cyc();
        dev_rvalid_i = 1'b1;
        #2;
        chk("rst2_no_rvalid", host_rvalid_o, 0);
        cyc();
        dev_rvalid_i = 1'b0;
        #2;
        chk("rst2_perr_set", protocol_err_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
